// File: rtl/noc_pkg.sv
// noc_pkg: shared NoC router constants, FSM encodings and header field layout
package noc_pkg;

  localparam logic [4:0] DIR_LOCAL = 5'b00001;
  localparam logic [4:0] DIR_NORTH = 5'b00010;
  localparam logic [4:0] DIR_SOUTH = 5'b00100;
  localparam logic [4:0] DIR_EAST  = 5'b01000;
  localparam logic [4:0] DIR_WEST  = 5'b10000;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ROUTE = 2'd1,
    REQ   = 2'd2
  } state_e;

  // Header fields are packed down from the flit MSB: dest X first, then dest Y.
  localparam int HDR_X_FIELD = 0;
  localparam int HDR_Y_FIELD = 1;

  // MSB position of a header field inside a flit of the given width.
  function automatic int hdr_msb(input int data_w, input int coord_w, input int field);
    return data_w - 1 - field * coord_w;
  endfunction

endpackage

// File: rtl/xy_route_calc.sv
// xy_route_calc: combinational XY dimension-order route, destination to one-hot output direction
module xy_route_calc
  import noc_pkg::*;
#(
  parameter int COORD_W = 2,
  parameter int MY_X    = 0,
  parameter int MY_Y    = 0
) (
  input  logic [COORD_W-1:0] dest_x,
  input  logic [COORD_W-1:0] dest_y,
  output logic [4:0]         route
);

  localparam logic [COORD_W-1:0] MX = COORD_W'(MY_X);
  localparam logic [COORD_W-1:0] MY = COORD_W'(MY_Y);

  // Resolve X first, then Y; equal in both means the flit is for the local PE.
  always_comb begin
    route = (dest_x > MX) ? DIR_EAST  :
            (dest_x < MX) ? DIR_WEST  :
            (dest_y > MY) ? DIR_NORTH :
            (dest_y < MY) ? DIR_SOUTH : DIR_LOCAL;
  end

endmodule

// File: rtl/input_port_unit.sv
// input_port_unit: router input buffer with XY route computation and registered one-hot request
module input_port_unit
  import noc_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int DEPTH   = 2,
  parameter int COORD_W = 2,
  parameter int MY_X    = 0,
  parameter int MY_Y    = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic [4:0]        req,
  input  logic              grant,
  output logic [DATA_W-1:0] out_data,
  output logic              err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int X_MSB = hdr_msb(DATA_W, COORD_W, HDR_X_FIELD);
  localparam int Y_MSB = hdr_msb(DATA_W, COORD_W, HDR_Y_FIELD);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  state_e            state_q, state_d;
  logic [4:0]        req_q, req_d;
  logic              err_q, err_d;
  logic              push, pop;
  logic [DATA_W-1:0] head;
  logic [4:0]        route;

  assign head     = mem_q[rd_ptr_q];
  assign in_ready = count_q < CNT_W'(DEPTH);
  assign push     = in_valid && in_ready;
  assign pop      = grant && (state_q == REQ);
  assign req      = req_q;
  assign err      = err_q;
  assign out_data = (state_q == REQ) ? head : '0;

  xy_route_calc #(
    .COORD_W (COORD_W),
    .MY_X    (MY_X),
    .MY_Y    (MY_Y)
  ) u_route (
    .dest_x (head[X_MSB -: COORD_W]),
    .dest_y (head[Y_MSB -: COORD_W]),
    .route  (route)
  );

  // FIFO bookkeeping: pushes gated by in_ready, pops only from the REQ state.
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = in_data;
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    err_d    = err_q | (grant && (state_q != REQ));
  end

  // Request FSM: latch the head route for one cycle, hold it until granted, then bubble.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    case (state_q)
      EMPTY: state_d = push ? ROUTE : EMPTY;
      ROUTE: begin
        state_d = REQ;
        req_d   = route;
      end
      REQ: if (pop) begin
        req_d   = '0;
        state_d = (count_d != '0) ? ROUTE : EMPTY;
      end
      default: begin
        state_d = EMPTY;
        req_d   = '0;
      end
    endcase
  end

  // State registers; reset discards every buffered flit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= EMPTY;
      req_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      req_q    <= req_d;
      err_q    <= err_d;
    end
  end

endmodule
